// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the CRAM bitstream loader.
package fpga_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } cfg_state_t;

   localparam logic [15:0] CFG_CRC_POLY = 16'h1021;
   localparam logic [15:0] CFG_CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/fpga_config_loader_crc.sv
// Bit-serial CRC-16-CCITT over the shifted configuration stream (MSB-feedback form).
module cfg_crc16
   import fpga_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        bit_valid,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      crc_d = crc_q;
      fb    = crc_q[15] ^ bit_in;
      if (clr) begin
         crc_d = CFG_CRC_INIT;
      end else if (bit_valid) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CFG_CRC_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) crc_q <= CFG_CRC_INIT;
      else     crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/fpga_config_loader.sv
// Host-stream to CRAM scan-chain loader; holds the fabric in reset until the chain is full.
// Optional CRC check of the shifted stream is enabled with `define FPGA_CFG_CRC_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; done/error/fabric-release hold from last load
// ST_LOAD  | s_ready high, waiting for the next host word
// ST_SHIFT | one chain bit per cycle, LSB first
// ST_CHECK | (CRC build) accept one word holding the expected CRC
// ST_DONE  | one cycle; release fabric, flag done
// ST_ERROR | one cycle; flag error, fabric stays in reset
module fpga_config_loader
   import fpga_cfg_pkg::*;
#(
   parameter int WORD_W    = 16,
   parameter int CHAIN_LEN = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              cram_en,
   output logic              cram_config_en,
   output logic              cram_data,
   output logic              le_nrst_out,
   output logic              le_en_out,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int BW = $clog2(CHAIN_LEN + 1);
   localparam int WW = $clog2(WORD_W + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(CHAIN_LEN - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(WORD_W - 1);

   cfg_state_t        state_q, state_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WW-1:0]     wcnt_q, wcnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic              s_ready_q, cram_en_q, busy_q;
   logic              done_q, done_d;
   logic              le_nrst_q, le_nrst_d;

`ifdef FPGA_CFG_CRC_EN
   logic        error_q, error_d;
   logic [15:0] crc;

   cfg_crc16 u_crc (
      .clk       (clk),
      .rst       (rst),
      .clr       (state_q == ST_IDLE && start),
      .bit_valid (state_q == ST_SHIFT),
      .bit_in    (shreg_q[0]),
      .crc       (crc)
   );
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      wcnt_d    = wcnt_q;
      shreg_d   = shreg_q;
      done_d    = done_q;
      le_nrst_d = le_nrst_q;
`ifdef FPGA_CFG_CRC_EN
      error_d   = error_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_LOAD;
               bit_cnt_d = '0;
               wcnt_d    = '0;
               done_d    = 1'b0;
               le_nrst_d = 1'b0;
`ifdef FPGA_CFG_CRC_EN
               error_d   = 1'b0;
`endif
            end
         end
         ST_LOAD: begin
            if (s_valid && s_ready_q) begin
               shreg_d = s_data;
               wcnt_d  = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            wcnt_d    = wcnt_q + 1'b1;
            shreg_d   = shreg_q >> 1;
            // Clearing the shifter on exit keeps cram_data low outside SHIFT
            // and drops the unused upper bits of a partial last word.
            if (wcnt_q == WORD_LAST || bit_cnt_q == BIT_LAST) begin
               shreg_d = '0;
               if (bit_cnt_q == BIT_LAST) begin
`ifdef FPGA_CFG_CRC_EN
                  state_d = ST_CHECK;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
`ifdef FPGA_CFG_CRC_EN
         ST_CHECK: begin
            if (s_valid && s_ready_q) begin
               state_d = (crc == s_data[15:0]) ? ST_DONE : ST_ERROR;
            end
         end
`endif
         ST_DONE:  state_d = ST_IDLE;
         ST_ERROR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (state_d == ST_DONE) begin
         done_d    = 1'b1;
         le_nrst_d = 1'b1;
      end
`ifdef FPGA_CFG_CRC_EN
      if (state_d == ST_ERROR) error_d = 1'b1;
`endif
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         wcnt_q    <= '0;
         shreg_q   <= '0;
         s_ready_q <= 1'b0;
         cram_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         le_nrst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         wcnt_q    <= wcnt_d;
         shreg_q   <= shreg_d;
         s_ready_q <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
         cram_en_q <= (state_d == ST_SHIFT);
         busy_q    <= (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_CHECK);
         done_q    <= done_d;
         le_nrst_q <= le_nrst_d;
      end
   end

`ifdef FPGA_CFG_CRC_EN
   always_ff @(posedge clk) begin
      if (rst) error_q <= 1'b0;
      else     error_q <= error_d;
   end
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign s_ready        = s_ready_q;
   assign cram_en        = cram_en_q;
   assign cram_config_en = cram_en_q;
   assign cram_data      = shreg_q[0];
   assign le_nrst_out    = le_nrst_q;
   assign le_en_out      = le_nrst_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader with a 20-bit chain; CRC scenarios under FPGA_CFG_CRC_EN.
module tb_fpga_config_loader;

`ifdef FPGA_CFG_CRC_EN
   localparam int WORD_W = 16;
`else
   localparam int WORD_W = 8;
`endif
   localparam int CHAIN_LEN = 20;
   localparam logic [19:0] REF_IMAGE = 20'hF3CA5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [WORD_W-1:0] s_data = '0;
   logic              s_valid = 1'b0;
   logic              s_ready, cram_en, cram_config_en, cram_data;
   logic              le_nrst_out, le_en_out, busy, done, error;

   fpga_config_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .cram_en        (cram_en),
      .cram_config_en (cram_config_en),
      .cram_data      (cram_data),
      .le_nrst_out    (le_nrst_out),
      .le_en_out      (le_en_out),
      .busy           (busy),
      .done           (done),
      .error          (error)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [1:0]  exp_q[$];          // {last_bit_of_load, expected cram_data}
   int          bits_seen = 0;
   logic        chk_next = 1'b0;
   logic        ref_clr = 1'b0;
   logic [19:0] ref_sr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] crc_model(input logic [19:0] bits);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < 20; i++) begin
         fb = c[15] ^ bits[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   // Reference chain: first bit shifted ends up at bit 0.
   always @(posedge clk) begin
      if (ref_clr) ref_sr <= '0;
      else if (cram_en && cram_config_en) ref_sr <= {cram_data, ref_sr[19:1]};
   end

   // Monitor: pops one expected bit per shift cycle.
   always @(negedge clk) begin
      logic [1:0] e;
      if (chk_next) begin
         chk_next = 1'b0;
         check("done_after_last_bit", done, 1);
         check("le_nrst_after_last_bit", le_nrst_out, 1);
         check("le_en_after_last_bit", le_en_out, 1);
         check("busy_after_last_bit", busy, 0);
         check("error_after_last_bit", error, 0);
      end
      if (!rst && cram_config_en) begin
         bits_seen++;
         check("cram_en_pair", cram_en, 1);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_shift: got shift with data %0b expected no shift at %0t", cram_data, $time);
         end else begin
            e = exp_q.pop_front();
            if (cram_data !== e[0]) begin
               errors++;
               $display("FAIL cram_data: got %0b expected %0b at %0t", cram_data, e[0], $time);
            end
`ifndef FPGA_CFG_CRC_EN
            if (e[1]) chk_next = 1'b1;
`endif
         end
      end
   end

   task automatic send_word(input logic [15:0] w, input int nbits, input bit last);
      int guard;
      for (int i = 0; i < nbits; i++) exp_q.push_back({last && (i == nbits - 1), w[i]});
      s_data  = w[WORD_W-1:0];
      s_valid = 1'b1;
      guard   = 0;
      while (!s_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("handshake_ready", s_ready, 1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic do_stall(input int n);
      int guard;
      if (n > 0) begin
         guard = 0;
         while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("stall_no_shift", cram_config_en, 0);
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_load(input int stall, input logic [15:0] crc_xor, input logic [15:0] last_w);
      int guard;
      @(negedge clk);
      ref_clr = 1'b1;
      @(negedge clk);
      ref_clr = 1'b0;
      bits_seen = 0;
      pulse_start();
      check("s_ready_after_start", s_ready, 1);
      check("busy_after_start", busy, 1);
      check("le_nrst_low_in_load", le_nrst_out, 0);
      check("done_cleared_by_start", done, 0);
      check("error_cleared_by_start", error, 0);
`ifdef FPGA_CFG_CRC_EN
      send_word(16'h3CA5, 16, 0);
      do_stall(stall);
      send_word(last_w, 4, 1);
`else
      send_word(16'h00A5, 8, 0);
      do_stall(stall);
      send_word(16'h003C, 8, 0);
      send_word(last_w, 4, 1);
`endif
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("stream_drained", exp_q.size(), 0);
`ifdef FPGA_CFG_CRC_EN
      send_word(crc_model(REF_IMAGE) ^ crc_xor, 0, 0);
      guard = 0;
      while (!done && !error && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("crc_done", done, (crc_xor == 16'h0) ? 1 : 0);
      check("crc_error", error, (crc_xor == 16'h0) ? 0 : 1);
      check("crc_le_nrst", le_nrst_out, (crc_xor == 16'h0) ? 1 : 0);
      check("crc_busy", busy, 0);
`else
      repeat (2) @(negedge clk);
`endif
      check("shift_count", bits_seen, CHAIN_LEN);
      check("ref_chain_image", ref_sr, REF_IMAGE);
      repeat (10) @(negedge clk);
      check("ref_chain_hold", ref_sr, REF_IMAGE);
      check("done_sticky", done, (crc_xor == 16'h0) ? 1 : 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_outputs_zero",
               {s_ready, cram_en, cram_config_en, cram_data, le_nrst_out,
                le_en_out, busy, done, error}, 0);
      end

      run_load(0, 16'h0000, 16'h000F);
      run_load(5, 16'h0000, 16'hF0AF);

      // Start mid-shift is ignored; reset lands on the ninth chain bit.
      pulse_start();
`ifdef FPGA_CFG_CRC_EN
      send_word(16'h3CA5, 16, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_midshift_start", busy, 1);
      repeat (7) @(negedge clk);
`else
      send_word(16'h00A5, 8, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_midshift_start", busy, 1);
      send_word(16'h003C, 8, 0);
`endif
      check("bit9_shifting", cram_config_en, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_cram_en", cram_en, 0);
      check("rst_cram_config_en", cram_config_en, 0);
      check("rst_cram_data", cram_data, 0);
      check("rst_le_nrst", le_nrst_out, 0);
      check("rst_le_en", le_en_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      exp_q.delete();
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_load(0, 16'h0000, 16'h000F);
`ifdef FPGA_CFG_CRC_EN
      run_load(0, 16'h0001, 16'h000F);
      check("error_sticky", error, 1);
      check("fabric_held_after_error", le_en_out, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
